alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle issue/control sequencer for the 8-bit datapath. It accepts 9-bit instructions from fetch over a valid/ready handshake and decodes them into ALU commands and operand selections. It consumes the ALU's result and flag outputs, holds the architectural carry and equal flags, and drives register-file writeback and branch resolution. It is the producing end of the ALU command interface and the consuming end of its flag outputs.

## Interface
- `NREG`, 8: register-file depth; register addresses are 3 bits.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `instr` input 9: instruction word; sampled only on acceptance.
- `instr_valid` input 1: fetch presents `instr`.
- `instr_ready` output 1: sequencer can accept; reset 1.
- `rf_raddr_a` / `rf_raddr_b` output 3 each: read addresses; reset 0.
- `rf_rdata_a` / `rf_rdata_b` input 8 each: combinational register-file read data.
- `alu_cmd` output 4: command to the ALU; reset 4'b1111 (nop).
- `alu_a` / `alu_b` output 8 each: ALU operands; reset 0.
- `alu_sc_i` output 1: current carry flag; reset 0.
- `alu_rslt` input 8: ALU result.
- `alu_sc_o`, `alu_equal`, `alu_wr_r0`, `alu_wr_first` input 1 each: ALU carry-out, equality, write-R0 and write-first-register indications.
- `rf_we` output 1: writeback strobe; reset 0.
- `rf_waddr` output 3: writeback address; reset 0.
- `rf_wdata` output 8: writeback data; reset 0.
- `br_taken` output 1: one-cycle branch-taken pulse; reset 0.
- `br_idx` output 5: branch LUT index; reset 0.
- `halted` output 1: sticky halt; reset 0.
- `illegal` output 1: one-cycle pulse on undefined opcode; reset 0.

## Operation
- Instruction fields:
  - `op` = instr[8:5], `ra` = instr[4:2], `rb` = {1'b0, instr[1:0]}.
  - `imm2` = {6'b0, instr[1:0]}, `imm5` = {3'b0, instr[4:0]}.
- Register ops 0000–0110: `alu_a` = R[ra], `alu_b` = R[rb].
- addi 0111: `alu_a` = R[ra], `alu_b` = `imm2`.
- movi 1010: `alu_cmd` = 1010, `alu_a` = `imm5`; always writes R0.
- cmp 1101: `alu_a` = R[ra], `alu_b` = R[rb]; latches `alu_equal` into `eq_flag`; no register write.
- Branches, no ALU use, `alu_cmd` stays 1111:
  - bne 1000: taken if `eq_flag` is 0.
  - beq 1001: taken if `eq_flag` is 1.
  - `br_idx` = instr[4:0].
- clc 1011: carry flag cleared to 0.
- halt 1110: enter HALT.
- nop 1111: no effect.
- 1100: treated as nop and pulses `illegal` in WB.
- Carry flag update:
  - Loaded from `alu_sc_o` only for ops 0000, 0001, 0010, 0111.
  - Held for all other ops.
  - `alu_sc_i` always reflects the stored flag.
- Writeback destination:
  - `alu_wr_first` = 1 writes to `ra`.
  - else `alu_wr_r0` = 1 writes to R0.
  - else movi writes to R0.
  - else no write.
- Both ALU write flags set at once: `ra` wins.
- FSM states: IDLE → OPER → EXEC → WB → IDLE.
  - IDLE: `instr_ready` = 1. On `instr_valid` & `instr_ready`, latch `instr` and go to OPER.
  - OPER: drive `rf_raddr_a` / `rf_raddr_b`; register the selected operands.
  - EXEC: drive `alu_cmd` and the registered operands; register `alu_rslt` and the flags.
  - WB: assert `rf_we` / `br_taken` / `illegal` as decoded; update the carry and equal flags.
- After WB: go to IDLE; halt goes to HALT instead.
- HALT: `halted` = 1, `instr_ready` = 0. Exited only by `reset`.

## Timing
- Acceptance at edge N; the writeback edge is N+3. `rf_we` is high during the cycle between edges N+2 and N+3.
- Maximum throughput: one instruction per 4 cycles. `instr_ready` is low in OPER, EXEC, WB and HALT.
- `rf_we`, `br_taken` and `illegal` are high for exactly one cycle, in WB only.
- `alu_cmd` equals the decoded op only during EXEC; it is 1111 in every other state.
- Flags become visible to the next instruction's EXEC, with no forwarding hazard because issue is serialized.
- `reset` in any state, including mid-EXEC or WB:
  - Next state is IDLE; carry and equal flags are 0.
  - Suppresses any pending write or branch in the same cycle.
  - Outputs take their reset values.
- `instr_valid` deasserted in IDLE: remain idle with no side effects.

## Structure
- Package `alu_seq_pkg`:
  - Opcode enum: ADD, LSH, RSH, MOV, OR, XOR, AND, ADDI, BNE, BEQ, MOVI, CLC, RSV, HALT, CMP, NOP.
  - State enum: IDLE, OPER, EXEC, WB, HALT.
  - Field-position constants.
- Sub-module `instr_decode`: combinational. Produces the op, register addresses, immediates, operand selects, and the flags for carry-update, branch and halt.
- FSM, flag registers and pipeline registers live in the top level.

## Test plan
- R1 = 0x0F, R2 = 0x01, carry = 0; add (0000, ra=1, rb=2) → writes R1 = 0x10 at the 3rd edge after acceptance; carry = 0.
- R1 = 0xFF, carry = 0; addi (0111, ra=1, imm=01) → writes R0 = 0x00; carry = 1. The next add then drives `alu_sc_i` = 1. A following clc sets carry back to 0.
- R1 = 0x05, R2 = 0x05; cmp → no write, `eq_flag` = 1. beq idx 0x13 → `br_taken` 1 cycle with `br_idx` = 0x13. bne → `br_taken` = 0.
- movi 0x1A → writes R0 = 0x1A. Opcode 1100 → `illegal` pulse and no write.
- Back-to-back `instr_valid` held high: `instr_ready` pattern is 1,0,0,0 repeating, and each instruction is accepted exactly once.
- halt → `halted` = 1 and `instr_ready` stays 0 over 20 cycles. `reset` asserted during EXEC of an add → no `rf_we` and all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and field positions for the issue/control sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam int INSTR_W = 9;
    localparam int DATA_W  = 8;
    localparam int NREG    = 8;
    localparam int RADDR_W = 3;
    localparam int CMD_W   = 4;
    localparam int IDX_W   = 5;

    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 5;
    localparam int RA_MSB  = 4;
    localparam int RA_LSB  = 2;
    localparam int RB_MSB  = 1;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 4;

    typedef enum logic [CMD_W-1:0] {
        OP_ADD  = 4'b0000,
        OP_LSH  = 4'b0001,
        OP_RSH  = 4'b0010,
        OP_MOV  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_AND  = 4'b0110,
        OP_ADDI = 4'b0111,
        OP_BNE  = 4'b1000,
        OP_BEQ  = 4'b1001,
        OP_MOVI = 4'b1010,
        OP_CLC  = 4'b1011,
        OP_RSV  = 4'b1100,
        OP_HALT = 4'b1101 + 4'b0001,
        OP_CMP  = 4'b1101,
        OP_NOP  = 4'b1111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPER,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        SEL_REG,
        SEL_IMM,
        SEL_ZERO
    } opnd_sel_e;

    localparam logic [INSTR_W-1:0] INSTR_NOP = {OP_NOP, 5'b0};

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Fetch, register-file and ALU signals seen by the sequencer.
// Latency: n/a (wiring only).
// Backpressure: instr_valid/instr_ready handshake from fetch.
interface alu_seq_ctrl_if;
    import alu_seq_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [RADDR_W-1:0] rf_raddr_a;
    logic [RADDR_W-1:0] rf_raddr_b;
    logic [DATA_W-1:0]  rf_rdata_a;
    logic [DATA_W-1:0]  rf_rdata_b;
    logic [CMD_W-1:0]   alu_cmd;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic               alu_sc_i;
    logic [DATA_W-1:0]  alu_rslt;
    logic               alu_sc_o;
    logic               alu_equal;
    logic               alu_wr_r0;
    logic               alu_wr_first;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic               br_taken;
    logic [IDX_W-1:0]   br_idx;
    logic               halted;
    logic               illegal;

    modport master (
        input  instr, instr_valid, rf_rdata_a, rf_rdata_b,
               alu_rslt, alu_sc_o, alu_equal, alu_wr_r0, alu_wr_first,
        output instr_ready, rf_raddr_a, rf_raddr_b, alu_cmd, alu_a, alu_b,
               alu_sc_i, rf_we, rf_waddr, rf_wdata, br_taken, br_idx,
               halted, illegal
    );

    modport slave (
        output instr, instr_valid, rf_rdata_a, rf_rdata_b,
               alu_rslt, alu_sc_o, alu_equal, alu_wr_r0, alu_wr_first,
        input  instr_ready, rf_raddr_a, rf_raddr_b, alu_cmd, alu_a, alu_b,
               alu_sc_i, rf_we, rf_waddr, rf_wdata, br_taken, br_idx,
               halted, illegal
    );

endinterface

// File: rtl/alu_seq_ctrl_decode.sv
// Combinational instruction decoder for the sequencer.
// Latency: 0 cycles.
// Backpressure: none.
module instr_decode
    import alu_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output op_e                op,
    output logic [RADDR_W-1:0] ra,
    output logic [RADDR_W-1:0] rb,
    output logic [DATA_W-1:0]  imm2,
    output logic [DATA_W-1:0]  imm5,
    output opnd_sel_e          sel_a,
    output opnd_sel_e          sel_b,
    output logic               uses_alu,
    output logic               may_write,
    output logic               is_movi,
    output logic               carry_upd,
    output logic               carry_clr,
    output logic               eq_upd,
    output logic               is_branch,
    output logic               br_on_eq,
    output logic               is_halt,
    output logic               is_illegal
);

    op_e opc;

    always_comb begin
        opc        = op_e'(instr[OP_MSB:OP_LSB]);
        op         = opc;
        ra         = instr[RA_MSB:RA_LSB];
        rb         = {1'b0, instr[RB_MSB:RB_LSB]};
        imm2       = {6'b0, instr[RB_MSB:RB_LSB]};
        imm5       = {3'b0, instr[IMM_MSB:0]};
        sel_a      = SEL_ZERO;
        sel_b      = SEL_ZERO;
        uses_alu   = 1'b0;
        may_write  = 1'b0;
        is_movi    = 1'b0;
        carry_upd  = 1'b0;
        carry_clr  = 1'b0;
        eq_upd     = 1'b0;
        is_branch  = 1'b0;
        br_on_eq   = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        unique case (opc)
            OP_ADD, OP_LSH, OP_RSH, OP_MOV, OP_OR, OP_XOR, OP_AND: begin
                sel_a     = SEL_REG;
                sel_b     = SEL_REG;
                uses_alu  = 1'b1;
                may_write = 1'b1;
                carry_upd = (opc == OP_ADD) || (opc == OP_LSH) || (opc == OP_RSH);
            end
            OP_ADDI: begin
                sel_a     = SEL_REG;
                sel_b     = SEL_IMM;
                uses_alu  = 1'b1;
                may_write = 1'b1;
                carry_upd = 1'b1;
            end
            OP_MOVI: begin
                sel_a     = SEL_IMM;
                uses_alu  = 1'b1;
                may_write = 1'b1;
                is_movi   = 1'b1;
            end
            OP_CMP: begin
                sel_a    = SEL_REG;
                sel_b    = SEL_REG;
                uses_alu = 1'b1;
                eq_upd   = 1'b1;
            end
            OP_BNE:  is_branch = 1'b1;
            OP_BEQ: begin
                is_branch = 1'b1;
                br_on_eq  = 1'b1;
            end
            OP_CLC:  carry_clr  = 1'b1;
            OP_HALT: is_halt    = 1'b1;
            OP_RSV:  is_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Serial issue sequencer: IDLE->OPER->EXEC->WB, one instruction per 4 cycles.
// Latency: writeback edge is 3 edges after acceptance.
// Backpressure: instr_ready only in IDLE; HALT blocks fetch until reset.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_seq_ctrl_if.master bus
);

    localparam int RA_W = $clog2(NREG);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  opa_q, opb_q, rslt_q;
    logic               sc_q, eq_q, wr_r0_q, wr_first_q;
    logic               carry_q, eq_flag_q;

    op_e                dec_op;
    logic [RADDR_W-1:0] dec_ra, dec_rb;
    logic [DATA_W-1:0]  dec_imm2, dec_imm5;
    opnd_sel_e          dec_sel_a, dec_sel_b;
    logic               dec_uses_alu, dec_may_write, dec_is_movi;
    logic               dec_carry_upd, dec_carry_clr, dec_eq_upd;
    logic               dec_is_branch, dec_br_on_eq, dec_is_halt, dec_is_illegal;

    logic [DATA_W-1:0]  opnd_a, opnd_b;
    logic               wr_en;
    logic [RA_W-1:0]    wr_addr;

    instr_decode u_decode (
        .instr      (instr_q),
        .op         (dec_op),
        .ra         (dec_ra),
        .rb         (dec_rb),
        .imm2       (dec_imm2),
        .imm5       (dec_imm5),
        .sel_a      (dec_sel_a),
        .sel_b      (dec_sel_b),
        .uses_alu   (dec_uses_alu),
        .may_write  (dec_may_write),
        .is_movi    (dec_is_movi),
        .carry_upd  (dec_carry_upd),
        .carry_clr  (dec_carry_clr),
        .eq_upd     (dec_eq_upd),
        .is_branch  (dec_is_branch),
        .br_on_eq   (dec_br_on_eq),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    always_comb begin
        unique case (dec_sel_a)
            SEL_REG: opnd_a = bus.rf_rdata_a;
            SEL_IMM: opnd_a = dec_imm5;
            default: opnd_a = '0;
        endcase
        unique case (dec_sel_b)
            SEL_REG: opnd_b = bus.rf_rdata_b;
            SEL_IMM: opnd_b = dec_imm2;
            default: opnd_b = '0;
        endcase
    end

    // Destination priority: write-first (ra) beats write-R0, which beats movi's implicit R0.
    assign wr_en   = dec_may_write && (wr_first_q || wr_r0_q || dec_is_movi);
    assign wr_addr = wr_first_q ? dec_ra : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            instr_q    <= INSTR_NOP;
            opa_q      <= '0;
            opb_q      <= '0;
            rslt_q     <= '0;
            sc_q       <= 1'b0;
            eq_q       <= 1'b0;
            wr_r0_q    <= 1'b0;
            wr_first_q <= 1'b0;
            carry_q    <= 1'b0;
            eq_flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.instr_valid) begin
                instr_q <= bus.instr;
            end
            if (state_q == ST_OPER) begin
                opa_q <= opnd_a;
                opb_q <= opnd_b;
            end
            if (state_q == ST_EXEC) begin
                rslt_q     <= bus.alu_rslt;
                sc_q       <= bus.alu_sc_o;
                eq_q       <= bus.alu_equal;
                wr_r0_q    <= bus.alu_wr_r0;
                wr_first_q <= bus.alu_wr_first;
            end
            if (state_q == ST_WB) begin
                if (dec_carry_clr) begin
                    carry_q <= 1'b0;
                end else if (dec_carry_upd) begin
                    carry_q <= sc_q;
                end
                if (dec_eq_upd) begin
                    eq_flag_q <= eq_q;
                end
            end
        end
    end

    assign bus.alu_sc_i = carry_q;

    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        bus.rf_raddr_a  = '0;
        bus.rf_raddr_b  = '0;
        bus.alu_cmd     = OP_NOP;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.rf_we       = 1'b0;
        bus.rf_waddr    = '0;
        bus.rf_wdata    = '0;
        bus.br_taken    = 1'b0;
        bus.br_idx      = '0;
        bus.halted      = 1'b0;
        bus.illegal     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_d = ST_OPER;
                end
            end
            ST_OPER: begin
                bus.rf_raddr_a = dec_ra;
                bus.rf_raddr_b = dec_rb;
                state_d        = ST_EXEC;
            end
            ST_EXEC: begin
                bus.alu_cmd = dec_uses_alu ? dec_op : OP_NOP;
                bus.alu_a   = opa_q;
                bus.alu_b   = opb_q;
                state_d     = ST_WB;
            end
            ST_WB: begin
                // A reset landing on the WB cycle cancels the side effects in that same cycle.
                if (!reset) begin
                    bus.rf_we    = wr_en;
                    bus.rf_waddr = wr_en ? wr_addr : '0;
                    bus.rf_wdata = wr_en ? rslt_q : '0;
                    bus.br_taken = dec_is_branch && (dec_br_on_eq ? eq_flag_q : !eq_flag_q);
                    bus.br_idx   = dec_is_branch ? instr_q[IMM_MSB:0] : '0;
                    bus.illegal  = dec_is_illegal;
                end
                state_d = dec_is_halt ? ST_HALT : ST_IDLE;
            end
            ST_HALT: begin
                bus.halted = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a register-file model and a small ALU stub.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_seq_ctrl_if bus();

    alu_seq_ctrl #(.NREG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    logic [7:0] rf [8];
    logic       poke_vld = 1'b0;
    logic [2:0] poke_addr = '0;
    logic [7:0] poke_val = '0;
    logic       both_wr = 1'b0;
    int         we_count = 0;

    always @(posedge clk) begin
        if (bus.rf_we) begin
            rf[bus.rf_waddr] <= bus.rf_wdata;
            we_count <= we_count + 1;
        end
        if (poke_vld) rf[poke_addr] <= poke_val;
    end

    // Register file read ports and ALU stub: add/addi without carry-in, movi passes A, cmp compares.
    always_comb begin
        bus.rf_rdata_a   = rf[bus.rf_raddr_a];
        bus.rf_rdata_b   = rf[bus.rf_raddr_b];
        bus.alu_rslt     = '0;
        bus.alu_sc_o     = 1'b0;
        bus.alu_equal    = 1'b0;
        bus.alu_wr_r0    = 1'b0;
        bus.alu_wr_first = 1'b0;
        case (bus.alu_cmd)
            4'b0000: begin
                {bus.alu_sc_o, bus.alu_rslt} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_wr_first = 1'b1;
                bus.alu_wr_r0    = both_wr;
            end
            4'b0111: begin
                {bus.alu_sc_o, bus.alu_rslt} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_wr_r0 = 1'b1;
            end
            4'b1010: bus.alu_rslt  = bus.alu_a;
            4'b1101: bus.alu_equal = (bus.alu_a == bus.alu_b);
            default: ;
        endcase
    end

    int         r_we_n, r_we_k, r_br_n, r_br_k, r_ill_n, r_ill_k, r_cmd_other_bad;
    logic [2:0] r_waddr;
    logic [7:0] r_wdata;
    logic [4:0] r_idx;
    logic [3:0] r_cmd_exec;
    logic       r_sc_exec;

    task automatic poke(input logic [2:0] a, input logic [7:0] v);
        @(negedge clk);
        poke_addr = a;
        poke_val  = v;
        poke_vld  = 1'b1;
        @(posedge clk);
        #1 poke_vld = 1'b0;
    endtask

    // Issues one instruction and records what the DUT drives over the next four cycles (k=1..4).
    task automatic run_instr(input logic [8:0] ins);
        int waited = 0;
        r_we_n = 0; r_we_k = 0; r_br_n = 0; r_br_k = 0; r_ill_n = 0; r_ill_k = 0;
        r_cmd_other_bad = 0; r_waddr = '0; r_wdata = '0; r_idx = '0;
        r_cmd_exec = 4'hF; r_sc_exec = 1'b0;
        @(negedge clk);
        while (!bus.instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.instr_ready) begin
            total++; bad++;
            $display("FAIL issue_timeout: instr_ready=%b required=1 ins=%h", bus.instr_ready, ins);
            return;
        end
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.rf_we) begin
                r_we_n++; r_we_k = k; r_waddr = bus.rf_waddr; r_wdata = bus.rf_wdata;
            end
            if (bus.br_taken) begin
                r_br_n++; r_br_k = k; r_idx = bus.br_idx;
            end
            if (bus.illegal) begin
                r_ill_n++; r_ill_k = k;
            end
            if (k == 2) begin
                r_cmd_exec = bus.alu_cmd; r_sc_exec = bus.alu_sc_i;
            end else if (bus.alu_cmd !== 4'hF) begin
                r_cmd_other_bad++;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got=%b want=1", bus.instr_ready); end
        total++; if (bus.alu_cmd !== 4'hF) begin bad++; $display("FAIL rst_cmd: got=%h want=f", bus.alu_cmd); end
        total++; if ({bus.rf_we, bus.br_taken, bus.illegal, bus.halted, bus.alu_sc_i} !== 5'b0) begin
            bad++; $display("FAIL rst_strobes: got=%b want=00000", {bus.rf_we, bus.br_taken, bus.illegal, bus.halted, bus.alu_sc_i});
        end
        total++; if ({bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_a, bus.alu_b, bus.br_idx} !== '0) begin
            bad++; $display("FAIL rst_buses: raddr_a=%h alu_a=%h br_idx=%h want all 0", bus.rf_raddr_a, bus.alu_a, bus.br_idx);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle;
        int w0 = we_count;
        int not_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.instr_ready !== 1'b1) not_ready++;
        end
        total++; if (not_ready != 0 || we_count != w0) begin
            bad++; $display("FAIL idle_quiet: not_ready_cycles=%0d writes=%0d want 0 and 0", not_ready, we_count - w0);
        end
    endtask

    task automatic test_add;
        poke(3'd1, 8'h0F);
        poke(3'd2, 8'h01);
        run_instr(9'b0000_001_10);
        total++; if (r_we_n != 1 || r_we_k != 3) begin bad++; $display("FAIL add_we_timing: pulses=%0d cycle=%0d want 1 at 3", r_we_n, r_we_k); end
        total++; if (r_waddr !== 3'd1 || r_wdata !== 8'h10) begin bad++; $display("FAIL add_wb: addr=%0d data=%h want 1/10", r_waddr, r_wdata); end
        total++; if (r_cmd_exec !== 4'h0 || r_cmd_other_bad != 0) begin
            bad++; $display("FAIL add_cmd: exec=%h off_exec_bad=%0d want 0/0", r_cmd_exec, r_cmd_other_bad);
        end
        total++; if (bus.alu_sc_i !== 1'b0) begin bad++; $display("FAIL add_carry: got=%b want=0", bus.alu_sc_i); end
        total++; if (rf[1] !== 8'h10) begin bad++; $display("FAIL add_rf: R1=%h want=10", rf[1]); end
    endtask

    task automatic test_carry;
        poke(3'd1, 8'hFF);
        run_instr(9'b0111_001_01);
        total++; if (r_we_n != 1 || r_waddr !== 3'd0 || r_wdata !== 8'h00) begin
            bad++; $display("FAIL addi_wb: n=%0d addr=%0d data=%h want 1/0/00", r_we_n, r_waddr, r_wdata);
        end
        total++; if (bus.alu_sc_i !== 1'b1) begin bad++; $display("FAIL addi_carry: got=%b want=1", bus.alu_sc_i); end
        run_instr(9'b0000_001_10);
        total++; if (r_sc_exec !== 1'b1) begin bad++; $display("FAIL add_sc_i: got=%b want=1", r_sc_exec); end
        run_instr(9'b1011_00000);
        total++; if (bus.alu_sc_i !== 1'b0 || r_we_n != 0 || r_cmd_exec !== 4'hF) begin
            bad++; $display("FAIL clc: carry=%b writes=%0d cmd=%h want 0/0/f", bus.alu_sc_i, r_we_n, r_cmd_exec);
        end
    endtask

    task automatic test_branch;
        poke(3'd1, 8'h05);
        poke(3'd2, 8'h05);
        run_instr(9'b1101_001_10);
        total++; if (r_we_n != 0 || r_cmd_exec !== 4'hD) begin bad++; $display("FAIL cmp: writes=%0d cmd=%h want 0/d", r_we_n, r_cmd_exec); end
        run_instr(9'b1001_10011);
        total++; if (r_br_n != 1 || r_br_k != 3 || r_idx !== 5'h13) begin
            bad++; $display("FAIL beq_taken: pulses=%0d cycle=%0d idx=%h want 1/3/13", r_br_n, r_br_k, r_idx);
        end
        run_instr(9'b1000_00101);
        total++; if (r_br_n != 0 || r_cmd_exec !== 4'hF) begin bad++; $display("FAIL bne_not_taken: pulses=%0d cmd=%h want 0/f", r_br_n, r_cmd_exec); end
    endtask

    task automatic test_movi_illegal;
        run_instr(9'b1010_11010);
        total++; if (r_we_n != 1 || r_we_k != 3 || r_waddr !== 3'd0 || r_wdata !== 8'h1A) begin
            bad++; $display("FAIL movi: n=%0d cycle=%0d addr=%0d data=%h want 1/3/0/1a", r_we_n, r_we_k, r_waddr, r_wdata);
        end
        total++; if (r_cmd_exec !== 4'hA) begin bad++; $display("FAIL movi_cmd: got=%h want=a", r_cmd_exec); end
        run_instr(9'b1100_00000);
        total++; if (r_ill_n != 1 || r_ill_k != 3 || r_we_n != 0) begin
            bad++; $display("FAIL illegal: pulses=%0d cycle=%0d writes=%0d want 1/3/0", r_ill_n, r_ill_k, r_we_n);
        end
    endtask

    task automatic test_both_wr;
        poke(3'd3, 8'h20);
        both_wr = 1'b1;
        run_instr(9'b0000_011_00);
        both_wr = 1'b0;
        total++; if (r_waddr !== 3'd3 || r_wdata !== 8'h3A) begin bad++; $display("FAIL both_wr: addr=%0d data=%h want 3/3a", r_waddr, r_wdata); end
    endtask

    task automatic test_back_to_back;
        logic [8:0] seq [3];
        int accepted = 0;
        int patt_bad = 0;
        int w0;
        logic acc;
        seq[0] = 9'b1010_00001;
        seq[1] = 9'b1010_00010;
        seq[2] = 9'b1010_00011;
        @(negedge clk);
        w0 = we_count;
        bus.instr = seq[0];
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.instr_ready !== ((i % 4) == 0)) patt_bad++;
            acc = bus.instr_ready && bus.instr_valid;
            @(posedge clk);
            #1;
            if (acc) begin
                accepted++;
                if (accepted < 3) bus.instr = seq[accepted];
                else bus.instr_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        total++; if (patt_bad != 0) begin bad++; $display("FAIL b2b_ready_pattern: wrong_cycles=%0d want 0", patt_bad); end
        total++; if (accepted != 3 || we_count - w0 != 3) begin
            bad++; $display("FAIL b2b_accept: accepted=%0d writes=%0d want 3/3", accepted, we_count - w0);
        end
        total++; if (rf[0] !== 8'h03) begin bad++; $display("FAIL b2b_last: R0=%h want=03", rf[0]); end
    endtask

    task automatic test_halt;
        int halt_bad = 0;
        run_instr(9'b1110_00000);
        total++; if (bus.halted !== 1'b1 || r_we_n != 0) begin bad++; $display("FAIL halt_enter: halted=%b writes=%0d want 1/0", bus.halted, r_we_n); end
        bus.instr = INSTR_NOP;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.halted !== 1'b1 || bus.instr_ready !== 1'b0) halt_bad++;
        end
        bus.instr_valid = 1'b0;
        total++; if (halt_bad != 0) begin bad++; $display("FAIL halt_sticky: bad_cycles=%0d want 0", halt_bad); end
    endtask

    task automatic test_reset_mid;
        int w0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (bus.halted !== 1'b0 || bus.instr_ready !== 1'b1) begin
            bad++; $display("FAIL halt_exit: halted=%b ready=%b want 0/1", bus.halted, bus.instr_ready);
        end
        poke(3'd1, 8'hFF);
        run_instr(9'b0111_001_01);
        poke(3'd1, 8'h0F);
        poke(3'd2, 8'h01);
        total++; if (bus.alu_sc_i !== 1'b1) begin bad++; $display("FAIL pre_reset_carry: got=%b want=1", bus.alu_sc_i); end
        w0 = we_count;
        @(negedge clk);
        bus.instr = 9'b0000_001_10;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.alu_cmd !== 4'h0) begin bad++; $display("FAIL mid_exec_cmd: got=%h want=0", bus.alu_cmd); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b0 || bus.alu_cmd !== 4'hF || bus.instr_ready !== 1'b1 || bus.alu_sc_i !== 1'b0 || bus.alu_a !== 8'h00) begin
            bad++; $display("FAIL reset_exec_outputs: we=%b cmd=%h ready=%b sc=%b a=%h want 0/f/1/0/00",
                            bus.rf_we, bus.alu_cmd, bus.instr_ready, bus.alu_sc_i, bus.alu_a);
        end
        repeat (4) @(negedge clk);
        total++; if (we_count != w0 || rf[1] !== 8'h0F) begin
            bad++; $display("FAIL reset_exec_nowrite: writes=%0d R1=%h want 0/0f", we_count - w0, rf[1]);
        end
        // Reset arriving on the WB cycle itself must mask the writeback strobe.
        w0 = we_count;
        @(negedge clk);
        bus.instr = 9'b1010_00111;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_wb_we: got=%b want=0", bus.rf_we); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (we_count != w0) begin bad++; $display("FAIL reset_wb_nowrite: writes=%0d want 0", we_count - w0); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        bus.instr = INSTR_NOP;
        bus.instr_valid = 1'b0;
        test_reset();
        test_idle();
        test_add();
        test_carry();
        test_branch();
        test_movi_illegal();
        test_both_wr();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
